// File: rtl/apb_pkg.sv
// Shared APB bus dimensions for the requesters and slaves in this design.
package apb_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: converts one valid/ready command into a SETUP+ACCESS transfer
// and returns a held response, aborting transfers whose slave never raises pready.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort when the counter is one short of the limit and pready is still low,
    // i.e. on the TIMEOUT_CYCLES-th ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
    logic                  pwrite_reg, pwrite_next;
    logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
    logic                  psel_reg, psel_next;
    logic                  penable_reg, penable_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;
    logic [CNT_W-1:0]      wait_cnt_reg, wait_cnt_next;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg       <= IDLE;
            paddr_reg       <= '0;
            pwrite_reg      <= 1'b0;
            pwdata_reg      <= '0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            wait_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            paddr_reg       <= paddr_next;
            pwrite_reg      <= pwrite_next;
            pwdata_reg      <= pwdata_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
            wait_cnt_reg    <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        paddr_next       = paddr_reg;
        pwrite_next      = pwrite_reg;
        pwdata_next      = pwdata_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        wait_cnt_next    = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_next  = cmd_addr;
                    pwrite_next = cmd_write;
                    pwdata_next = cmd_wdata;
                    psel_next   = 1'b1;
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_rdata_next   = pwrite_reg ? '0 : prdata;
                    rsp_err_next     = pslverr;
                    rsp_timeout_next = 1'b0;
                    state_next       = RESP;
                end else begin
                    if (wait_cnt_reg != '1) begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                    if (TIMEOUT_CYCLES != 0 && wait_cnt_reg == CNT_LAST) begin
                        psel_next        = 1'b0;
                        penable_next     = 1'b0;
                        rsp_valid_next   = 1'b1;
                        rsp_rdata_next   = '0;
                        rsp_err_next     = 1'b1;
                        rsp_timeout_next = 1'b1;
                        state_next       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    wait_cnt_next  = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign paddr       = paddr_reg;
    assign pwrite      = pwrite_reg;
    assign pwdata      = pwdata_reg;
    assign psel        = psel_reg;
    assign penable     = penable_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a bench-side APB slave plus a
// transaction-level model of expected latency and response contents.
module tb_apb_master_bridge;
    localparam int AW = apb_pkg::ADDR_WIDTH;
    localparam int DW = apb_pkg::DATA_WIDTH;
    localparam int TMO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata = '0;
    logic          pready = 1'b0, pslverr = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One command through the bridge, called just after a falling edge while the
    // DUT is idle. The bench plays the slave: pready rises on ACCESS cycle
    // waits+1, and is random noise outside ACCESS.
    task automatic do_xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int waits, input logic err,
                           input logic [DW-1:0] rdata, input int rsp_delay, input logic hold);
        bit            exp_to    = (waits >= TMO);
        int            exp_acc   = exp_to ? TMO : waits + 1;
        logic          exp_err   = exp_to | err;
        logic [DW-1:0] exp_rdata = (wr || exp_to) ? '0 : rdata;
        int first_psel = -1, first_pen = -1, first_rsp = -1, acc = 0, k = 0, ready_k = -1;
        bit done = 0, bad_bus = 0, bad_stable = 0;
        logic [DW-1:0] got_rdata = '0;
        logic got_err = 1'b0, got_to = 1'b0;

        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s cmd_ready_idle: got %b expected 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        while (!done && k < 80) begin
            @(negedge pclk);
            k++;
            if (!hold) begin
                cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
            end
            if (psel && first_psel < 0) first_psel = k;
            if (penable && first_pen < 0) first_pen = k;
            if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wdata)) bad_bus = 1;
            if ((penable && !psel) || (psel && cmd_ready)) bad_bus = 1;
            if (penable) begin
                acc++;
                pready  = (acc == waits + 1);
                pslverr = pready & err;
                prdata  = pready ? rdata : DW'($urandom);
            end else begin
                pready = $urandom; pslverr = $urandom; prdata = $urandom;
            end
            if (rsp_valid) begin
                if (first_rsp < 0) begin
                    first_rsp = k; got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
                end else if (rsp_rdata !== got_rdata || rsp_err !== got_err || rsp_timeout !== got_to) begin
                    bad_stable = 1;
                end
                if (psel || penable || cmd_ready) bad_bus = 1;
                rsp_ready = (k - first_rsp >= rsp_delay);
                if (rsp_ready && ready_k < 0) ready_k = k;
            end else if (first_rsp >= 0) begin
                done = 1;
            end else begin
                rsp_ready = $urandom;
            end
        end
        rsp_ready = 1'b0;

        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s completion: no response handshake within %0d cycles", name, k);
        end
        tests_run++;
        if (first_psel != 1 || first_pen != 2) begin
            tests_failed++;
            $display("FAIL %s setup_timing: psel@%0d penable@%0d expected psel@1 penable@2", name, first_psel, first_pen);
        end
        tests_run++;
        if (acc != exp_acc || first_rsp != 2 + exp_acc) begin
            tests_failed++;
            $display("FAIL %s access_timing: access=%0d rsp@%0d expected access=%0d rsp@%0d",
                     name, acc, first_rsp, exp_acc, 2 + exp_acc);
        end
        tests_run++;
        if (got_rdata !== exp_rdata || got_err !== exp_err || got_to !== exp_to) begin
            tests_failed++;
            $display("FAIL %s response: rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                     name, got_rdata, got_err, got_to, exp_rdata, exp_err, exp_to);
        end
        tests_run++;
        if (bad_bus || bad_stable) begin
            tests_failed++;
            $display("FAIL %s protocol: bus_violation=%0d rsp_unstable=%0d expected 0 0", name, bad_bus, bad_stable);
        end
        tests_run++;
        if (k != ready_k + 1 || cmd_ready !== 1'b1 || psel !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s release: drop@%0d cmd_ready=%b psel=%b expected drop@%0d cmd_ready=1 psel=0",
                     name, k, cmd_ready, psel, ready_k + 1);
        end
    endtask

    task automatic test_reset();
        #2 presetn = 1'b0;
        #1;
        tests_run++;
        if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, pwrite} !== 6'b0 ||
            paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: psel=%b penable=%b rsp_valid=%b paddr=%h pwdata=%h rdata=%h expected all 0",
                     psel, penable, rsp_valid, paddr, pwdata, rsp_rdata);
        end
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_write_basic();
        do_xfer("write_basic", 1'b1, AW'(3), DW'(32'hA5), 0, 1'b0, DW'($urandom), 0, 1'b0);
    endtask

    task automatic test_read_wait();
        do_xfer("read_wait2", 1'b0, AW'(3), DW'($urandom), 2, 1'b0, DW'(32'hA5), 0, 1'b0);
    endtask

    task automatic test_slverr();
        do_xfer("write_slverr", 1'b1, AW'($urandom), DW'($urandom), 1, 1'b1, DW'($urandom), 0, 1'b0);
        do_xfer("read_slverr", 1'b0, AW'($urandom), DW'($urandom), 0, 1'b1, DW'(32'h1234_5678), 1, 1'b0);
    endtask

    task automatic test_timeout();
        do_xfer("timeout_read", 1'b0, AW'($urandom), DW'($urandom), 100, 1'b0, DW'($urandom), 0, 1'b0);
        do_xfer("last_wait_ok", 1'b0, AW'($urandom), DW'($urandom), TMO - 1, 1'b1, DW'(32'hCAFE), 0, 1'b0);
        do_xfer("timeout_write", 1'b1, AW'($urandom), DW'($urandom), TMO, 1'b0, DW'($urandom), 2, 1'b0);
    endtask

    task automatic test_rsp_backpressure();
        do_xfer("backpressure", 1'b1, AW'(32'h40), DW'(32'h77), 0, 1'b0, DW'($urandom), 5, 1'b1);
        do_xfer("after_backpressure", 1'b0, AW'(32'h44), DW'($urandom), 0, 1'b0, DW'(32'h99), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            do_xfer("back_to_back", i[0], AW'($urandom), DW'($urandom), 0, 1'b0, DW'($urandom), 0, (i != 2));
    endtask

    task automatic test_reset_mid_transfer();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(32'h10); cmd_wdata = '0;
        pready = 1'b0;
        @(negedge pclk); cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        tests_run++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_prep: psel=%b penable=%b expected 1 1", psel, penable);
        end
        #2 presetn = 1'b0;
        #1;
        tests_run++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || paddr !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: psel=%b penable=%b rsp_valid=%b paddr=%h expected 0 0 0 0",
                     psel, penable, rsp_valid, paddr);
        end
        @(negedge pclk); presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pready = $urandom;
            @(negedge pclk);
            tests_run++;
            if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_mid_after: cycle %0d rsp_valid=%b psel=%b cmd_ready=%b expected 0 0 1",
                         i, rsp_valid, psel, cmd_ready);
            end
        end
        pready = 1'b0;
        do_xfer("after_reset", 1'b1, AW'($urandom), DW'($urandom), 1, 1'b0, DW'($urandom), 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int waits = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 4) : $urandom_range(0, 4);
            do_xfer("random", 1'($urandom), AW'($urandom), DW'($urandom), waits, 1'($urandom),
                    DW'($urandom), $urandom_range(0, 3), (i != 29) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_backpressure();
        test_back_to_back();
        test_reset_mid_transfer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
